icache_refill: RTL and testbench
================================

Name: icache_refill

Overview:
- Miss-handling engine for the direct-mapped instruction cache.
- When fetch reports a miss, it reads the 4 instruction bytes over the shared byte-wide memory port, assembles them little-endian into a 32-bit word, and writes the word into the cache's write port (we/wpc/winst).
- In the same cycle it returns the instruction to fetch.
- Sits between IF, the memory arbiter and the icache.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- BYTES, 4, bytes per instruction word; fixed at 4, with assembled width 8*BYTES.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- rdy  input  1  global ready; 0 freezes all state.
- req_i  input  1  miss request from IF.
- pc_i  input  ADDR_W  missing PC; low 2 bits ignored.
- flush_i  input  1  abort the refill (branch redirect).
- mem_gnt_i  input  1  arbiter grants the memory port this cycle.
- mem_din_i  input  8  read data; carries the byte addressed in the previous issue cycle.
- mem_req_o  output  1  requesting the memory port.
- mem_addr_o  output  ADDR_W  byte address being read.
- busy_o  output  1  refill in progress (state != IDLE).
- cache_we_o  output  1  icache write strobe.
- cache_wpc_o  output  ADDR_W  word-aligned PC written.
- cache_winst_o  output  32  assembled instruction.
- done_o  output  1  pulse: instruction delivered to IF (same cycle as cache_we_o).

Behaviour:
- Reset: all outputs 0, state IDLE, issue_cnt=recv_cnt=0, byte buffer 0.
- rdy=0:
  - All registers hold; no issue and no capture.
  - mem_req_o and mem_addr_o keep their values.
  - The memory holds mem_din_i stable while rdy=0.
- States: IDLE, FETCH, DONE.
- IDLE:
  - If req_i && !flush_i, latch base={pc_i[ADDR_W-1:2],2'b00}, clear counters, go to FETCH.
  - Otherwise stay.
- FETCH:
  - mem_req_o=1 while issue_cnt<4; mem_addr_o=base+issue_cnt.
  - Issue happens when mem_req_o && mem_gnt_i && rdy: issue_cnt++, set pend=1 for the next cycle.
  - No grant: no issue, pend=0 next cycle, retry.
  - When pend=1: capture mem_din_i into byte[recv_cnt], recv_cnt++.
  - Capture is independent of the current grant, so a byte in flight when the grant drops is still captured.
  - After the 4th capture: next state DONE, mem_req_o=0.
- DONE, one cycle:
  - cache_we_o=1, done_o=1, cache_wpc_o=base, cache_winst_o={byte3,byte2,byte1,byte0}.
  - Next state IDLE; strobes return to 0.
- Requests are accepted only in IDLE. req_i in FETCH or DONE is ignored; IF holds req_i until done_o.
- Latency with continuous grant:
  - Cycle 0: accept.
  - Cycles 1–4: issue addresses base..base+3.
  - Cycles 2–5: capture.
  - Cycle 6: DONE.
  - Minimum request to done_o is 6 cycles. Each grant-less cycle adds 1.
- Flush:
  - flush_i=1 in any state, with rdy=1, means next state IDLE, counters and pend cleared, mem_req_o=0 next cycle.
  - No cache_we_o is produced for the aborted word; the in-flight byte is discarded.
  - flush_i during DONE: the write this cycle still completes (cache contents stay valid), but done_o is suppressed (forced 0).
  - flush_i and req_i together in IDLE: flush wins, the request is dropped.
- rst mid-refill: immediate return to reset values; no write is emitted.
- Address arithmetic is modulo 2^ADDR_W; base+3 never crosses a word since base is aligned.

Test Plan:
- Basic refill: rst, then req_i with pc_i=0x1006, grant always 1, memory bytes 0x13,0x05,0x10,0x00 at 0x1004..0x1007 -> mem_addr_o 0x1004..0x1007 in cycles 1–4; cycle 6: cache_we_o=1, cache_wpc_o=0x1004, cache_winst_o=0x00100513, done_o=1; cycle 7: all strobes 0.
- Grant gaps: same request, mem_gnt_i low in cycles 2 and 3 -> byte 0 is still captured, addresses resume at 0x1005, done_o arrives in cycle 8 with the correct word.
- rdy stall: rdy=0 for 3 cycles mid-FETCH -> counters and outputs frozen, completion delayed exactly 3 cycles, word correct.
- Flush mid-refill: flush_i in cycle 3 -> cycle 4 busy_o=0, mem_req_o=0, no cache_we_o; a new req at 0x2000 then completes normally with cache_wpc_o=0x2000.
- Simultaneous events: flush_i with req_i in IDLE -> stays IDLE. req_i held through DONE -> exactly one write, then re-accepted in IDLE.
- Reset mid-refill: rst asserted in cycle 4 -> all outputs 0 the next cycle, no write observed.

Source files
------------

// File: rtl/icache_refill_if.sv
// Bundle between the refill engine, fetch, the memory arbiter and the icache.
// The engine takes the master side; its environment takes the slave side.
interface icache_refill_if #(
  parameter int ADDR_W = 32
);
  logic              req_i;
  logic [ADDR_W-1:0] pc_i;
  logic              flush_i;
  logic              mem_gnt_i;
  logic [7:0]        mem_din_i;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              busy_o;
  logic              cache_we_o;
  logic [ADDR_W-1:0] cache_wpc_o;
  logic [31:0]       cache_winst_o;
  logic              done_o;

  modport master (
    input  req_i, pc_i, flush_i,
    input  mem_gnt_i, mem_din_i,
    output mem_req_o, mem_addr_o, busy_o,
    output cache_we_o, cache_wpc_o,
    output cache_winst_o, done_o
  );

  modport slave (
    output req_i, pc_i, flush_i,
    output mem_gnt_i, mem_din_i,
    input  mem_req_o, mem_addr_o, busy_o,
    input  cache_we_o, cache_wpc_o,
    input  cache_winst_o, done_o
  );
endinterface

// File: rtl/icache_refill.sv
// Instruction-cache miss engine: reads four bytes over the byte-wide
// memory port, assembles them little-endian and writes the icache.
module icache_refill #(
  parameter int ADDR_W = 32,
  parameter int BYTES  = 4
) (
  input logic             clk,
  input logic             rst,
  input logic             rdy,
  icache_refill_if.master bus
);
  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } state_t;

  localparam logic [2:0] NBYTE = 3'(BYTES);
  localparam logic [2:0] LAST  = 3'(BYTES - 1);

  state_t                  state, state_nx;
  logic [ADDR_W-1:0]       base;
  logic [2:0]              issue_cnt;
  logic [2:0]              recv_cnt;
  logic                    pend;
  logic [BYTES-1:0][7:0]   bytes_q;
  logic                    issue;
  logic                    capture;
  logic                    accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (rdy) begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx          = state;
    issue             = 1'b0;
    capture           = 1'b0;
    accept            = 1'b0;
    bus.mem_req_o     = 1'b0;
    bus.mem_addr_o    = '0;
    bus.cache_we_o    = 1'b0;
    bus.cache_wpc_o   = '0;
    bus.cache_winst_o = '0;
    bus.done_o        = 1'b0;
    bus.busy_o        = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (bus.req_i && !bus.flush_i) begin
          accept   = 1'b1;
          state_nx = FETCH;
        end
      end
      FETCH: begin
        bus.mem_req_o = (issue_cnt < NBYTE);
        if (bus.mem_req_o) begin
          bus.mem_addr_o = base + ADDR_W'(issue_cnt);
        end
        issue   = bus.mem_req_o && bus.mem_gnt_i && rdy;
        capture = pend && rdy;
        if (capture && recv_cnt == LAST) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        // The write lands even when flushed; only the IF handoff is dropped.
        bus.cache_we_o    = rdy;
        bus.done_o        = rdy && !bus.flush_i;
        bus.cache_wpc_o   = base;
        bus.cache_winst_o = bytes_q;
        state_nx          = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (bus.flush_i) begin
      state_nx = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base      <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      pend      <= 1'b0;
      bytes_q   <= '0;
    end else if (rdy) begin
      pend <= issue;
      if (accept) begin
        base      <= bus.pc_i & ~ADDR_W'(3);
        issue_cnt <= '0;
        recv_cnt  <= '0;
      end
      if (issue) begin
        issue_cnt <= issue_cnt + 3'd1;
      end
      if (capture) begin
        bytes_q[recv_cnt[1:0]] <= bus.mem_din_i;
        recv_cnt               <= recv_cnt + 3'd1;
      end
      if (bus.flush_i) begin
        issue_cnt <= '0;
        recv_cnt  <= '0;
        pend      <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: a transaction-level model checked every
// cycle, plus hand-computed expectations for the scenarios of interest.
module tb_icache_refill;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;

  icache_refill_if #(.ADDR_W(32)) bus ();

  icache_refill #(
    .ADDR_W(32),
    .BYTES (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int writes = 0;

  function automatic logic [7:0] mem_byte(logic [31:0] a);
    case (a)
      32'h1004: return 8'h13;
      32'h1005: return 8'h05;
      32'h1006: return 8'h10;
      32'h1007: return 8'h00;
      32'h2000: return 8'h93;
      32'h2001: return 8'h00;
      32'h2002: return 8'h10;
      32'h2003: return 8'h00;
      default:  return a[7:0] ^ 8'h5a;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {mem_byte(a + 3), mem_byte(a + 2),
            mem_byte(a + 1), mem_byte(a)};
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
    end
  endtask

  // Memory: returns the addressed byte one cycle after each granted issue.
  always @(posedge clk) begin
    if (rst) begin
      bus.mem_din_i <= 8'h00;
    end else if (rdy && bus.mem_req_o && bus.mem_gnt_i) begin
      bus.mem_din_i <= mem_byte(bus.mem_addr_o);
    end
  end

  // Model: refill progress as counts of bytes sent / received.
  bit          m_active, m_write, m_fly;
  int          m_sent, m_got;
  logic [31:0] m_base;
  logic        e_req, e_we, e_done;
  logic [31:0] e_addr, e_wpc, e_inst;

  initial begin
    m_active = 0; m_write = 0; m_fly = 0;
    m_sent = 0; m_got = 0; m_base = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_req  = m_active && m_sent < 4;
      e_addr = e_req ? m_base + 32'(m_sent) : 32'h0;
      e_we   = m_write && rdy;
      e_done = m_write && rdy && !bus.flush_i;
      e_wpc  = m_write ? m_base : 32'h0;
      e_inst = m_write ? mem_word(m_base) : 32'h0;
      chk("model busy", bus.busy_o, m_active || m_write);
      chk("model mem_req", bus.mem_req_o, e_req);
      chk("model mem_addr", bus.mem_addr_o, e_addr);
      chk("model we", bus.cache_we_o, e_we);
      chk("model done", bus.done_o, e_done);
      chk("model wpc", bus.cache_wpc_o, e_wpc);
      chk("model winst", bus.cache_winst_o, e_inst);
      if (rst) begin
        m_active = 0; m_write = 0; m_fly = 0;
        m_sent = 0; m_got = 0;
      end else if (rdy) begin
        if (bus.flush_i) begin
          m_active = 0; m_write = 0; m_fly = 0;
          m_sent = 0; m_got = 0;
        end else if (m_write) begin
          m_write = 0;
        end else if (m_active) begin
          if (m_fly) m_got++;
          m_fly = e_req && bus.mem_gnt_i;
          if (m_fly) m_sent++;
          if (m_got == 4) begin
            m_active = 0;
            m_write  = 1;
          end
        end else if (bus.req_i) begin
          m_active = 1;
          m_base   = {bus.pc_i[31:2], 2'b00};
          m_sent = 0; m_got = 0; m_fly = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(logic [31:0] pc);
    tick();
    bus.req_i = 1'b1;
    bus.pc_i  = pc;
  endtask

  initial begin
    bus.req_i = 1'b0; bus.pc_i = '0; bus.flush_i = 1'b0;
    bus.mem_gnt_i = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("reset busy", bus.busy_o, 0);
    chk("reset mem_req", bus.mem_req_o, 0);
    chk("reset we", bus.cache_we_o, 0);
    chk("reset winst", bus.cache_winst_o, 0);
    tick();
    rst = 1'b0;

    // basic refill
    start(32'h1006);
    for (int k = 1; k <= 7; k++) begin
      tick();
      bus.req_i = 1'b0;
      @(negedge clk);
      if (k <= 4) chk("basic addr", bus.mem_addr_o, 32'h1003 + k);
      if (k == 5) chk("basic req off", bus.mem_req_o, 0);
      if (k == 6) begin
        chk("basic we", bus.cache_we_o, 1);
        chk("basic wpc", bus.cache_wpc_o, 32'h1004);
        chk("basic winst", bus.cache_winst_o, 32'h0010_0513);
        chk("basic done", bus.done_o, 1);
      end
      if (k == 7) begin
        chk("basic post we", bus.cache_we_o, 0);
        chk("basic post done", bus.done_o, 0);
      end
    end

    // grant gaps in cycles 2 and 3
    start(32'h1006);
    for (int k = 1; k <= 9; k++) begin
      tick();
      bus.req_i     = 1'b0;
      bus.mem_gnt_i = !(k == 2 || k == 3);
      @(negedge clk);
      if (k == 4) chk("gap resume addr", bus.mem_addr_o, 32'h1005);
      if (k == 7) chk("gap early done", bus.done_o, 0);
      if (k == 8) begin
        chk("gap done", bus.done_o, 1);
        chk("gap winst", bus.cache_winst_o, 32'h0010_0513);
      end
    end
    bus.mem_gnt_i = 1'b1;

    // rdy low for cycles 2..4
    start(32'h1006);
    for (int k = 1; k <= 10; k++) begin
      tick();
      bus.req_i = 1'b0;
      rdy = !(k >= 2 && k <= 4);
      @(negedge clk);
      if (k >= 2 && k <= 4) begin
        chk("stall addr", bus.mem_addr_o, 32'h1005);
        chk("stall req", bus.mem_req_o, 1);
      end
      if (k == 8) chk("stall early done", bus.done_o, 0);
      if (k == 9) begin
        chk("stall done", bus.done_o, 1);
        chk("stall winst", bus.cache_winst_o, 32'h0010_0513);
      end
    end
    rdy = 1'b1;

    // flush in cycle 3, then a fresh refill at 0x2000
    start(32'h1006);
    for (int k = 1; k <= 5; k++) begin
      tick();
      bus.req_i   = 1'b0;
      bus.flush_i = (k == 3);
      @(negedge clk);
      if (k == 4) begin
        chk("flush busy", bus.busy_o, 0);
        chk("flush mem_req", bus.mem_req_o, 0);
        chk("flush we", bus.cache_we_o, 0);
      end
    end
    start(32'h2000);
    for (int k = 1; k <= 7; k++) begin
      tick();
      bus.req_i = 1'b0;
      @(negedge clk);
      if (k == 6) begin
        chk("refill2 wpc", bus.cache_wpc_o, 32'h2000);
        chk("refill2 winst", bus.cache_winst_o, 32'h0010_0093);
        chk("refill2 done", bus.done_o, 1);
      end
    end

    // flush together with req in IDLE
    tick();
    bus.req_i = 1'b1; bus.pc_i = 32'h1006; bus.flush_i = 1'b1;
    tick();
    bus.req_i = 1'b0; bus.flush_i = 1'b0;
    @(negedge clk);
    chk("flush+req idle", bus.busy_o, 0);

    // req held through DONE: one write, then re-accept
    start(32'h1006);
    writes = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k >= 9) bus.req_i = 1'b0;
      @(negedge clk);
      if (bus.cache_we_o) writes++;
      if (k == 8) begin
        chk("held writes", writes, 1);
        chk("held re-accept", bus.busy_o, 1);
      end
      if (k == 13) chk("held second done", bus.done_o, 1);
    end

    // flush during DONE: write completes, done suppressed
    start(32'h2000);
    for (int k = 1; k <= 7; k++) begin
      tick();
      bus.req_i   = 1'b0;
      bus.flush_i = (k == 6);
      @(negedge clk);
      if (k == 6) begin
        chk("dflush we", bus.cache_we_o, 1);
        chk("dflush done", bus.done_o, 0);
        chk("dflush wpc", bus.cache_wpc_o, 32'h2000);
      end
      if (k == 7) chk("dflush idle", bus.busy_o, 0);
    end

    // reset in cycle 4
    start(32'h1006);
    writes = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      bus.req_i = 1'b0;
      rst = (k == 4);
      @(negedge clk);
      if (k >= 5 && bus.cache_we_o) writes++;
      if (k == 5) begin
        chk("rst busy", bus.busy_o, 0);
        chk("rst mem_req", bus.mem_req_o, 0);
        chk("rst addr", bus.mem_addr_o, 0);
        chk("rst done", bus.done_o, 0);
        chk("rst winst", bus.cache_winst_o, 0);
      end
    end
    chk("rst no write", writes, 0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
